// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the time-multiplexed leaky-trace neuron.
package neuron_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE,
    S_REFRACT
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Wide enough to hold P_N_INPUTS full-scale products without overflow.
  function automatic int acc_width(input int in_w, input int w_w, input int n);
    return in_w + w_w + clog2(n);
  endfunction

endpackage

// File: rtl/neuron_trace.sv
// One synapse time-surface trace: reloads to full scale on an event,
// otherwise decays linearly and saturates at zero.
module neuron_trace #(
  parameter int P_WIDTH = 9,
  parameter int P_DECAY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_event,
  output logic [P_WIDTH-1:0] o_tr
);

  localparam logic [P_WIDTH-1:0] TR_MAX = '1;
  localparam logic [P_WIDTH-1:0] TR_DEC = P_WIDTH'(P_DECAY);

  logic [P_WIDTH-1:0] tr_q, tr_d;

  always_comb begin
    tr_d = tr_q;
    if (i_event) begin
      tr_d = TR_MAX;
    end else if (tr_q > TR_DEC) begin
      tr_d = tr_q - TR_DEC;
    end else begin
      tr_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tr_q <= '0;
    else       tr_q <= tr_d;
  end

  assign o_tr = tr_q;

endmodule

// File: rtl/neuron_nin.sv
// N-channel leaky-trace neuron: traces are snapshotted on an evaluate request,
// then weighted and summed one channel per cycle through a single MAC.
module neuron_nin
  import neuron_pkg::*;
#(
  parameter int  P_N_INPUTS     = 8,
  parameter int  P_INPUT_WIDTH  = 9,
  parameter int  P_WEIGHT_WIDTH = 9,
  parameter int  P_DECAY        = 1,
  parameter int  P_REFRACT      = 16,
  localparam int P_ACC_W        = acc_width(P_INPUT_WIDTH, P_WEIGHT_WIDTH, P_N_INPUTS)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [P_N_INPUTS-1:0]                i_event,
  input  logic [P_N_INPUTS*P_WEIGHT_WIDTH-1:0] i_weights,
  input  logic [P_ACC_W-1:0]                   i_threshold,
  input  logic                                 i_eval,
  output logic                                 o_busy,
  output logic [P_N_INPUTS*P_INPUT_WIDTH-1:0]  o_tr,
  output logic                                 o_valid,
  output logic                                 o_fire,
  output logic [P_ACC_W-1:0]                   o_lv,
  output logic [P_ACC_W-1:0]                   o_neuron_out
);

  localparam int IDX_W  = clog2(P_N_INPUTS);
  localparam int CNT_W  = (clog2(P_REFRACT + 1) > 0) ? clog2(P_REFRACT + 1) : 1;
  localparam int PROD_W = P_INPUT_WIDTH + P_WEIGHT_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(P_N_INPUTS - 1);
  localparam logic [CNT_W-1:0] REFRACT_LOAD = CNT_W'(P_REFRACT);

  for (genvar k = 0; k < P_N_INPUTS; k++) begin : g_trace
    neuron_trace #(
      .P_WIDTH(P_INPUT_WIDTH),
      .P_DECAY(P_DECAY)
    ) u_trace (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_event(i_event[k]),
      .o_tr   (o_tr[k*P_INPUT_WIDTH +: P_INPUT_WIDTH])
    );
  end

  state_t                                state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [P_ACC_W-1:0]                    acc_q, acc_d;
  logic [P_N_INPUTS*P_INPUT_WIDTH-1:0]   snap_q, snap_d;
  logic                                  valid_q, valid_d;
  logic                                  fire_q, fire_d;
  logic [P_ACC_W-1:0]                    lv_q, lv_d;
  logic [P_ACC_W-1:0]                    nout_q, nout_d;

  logic [P_INPUT_WIDTH-1:0]  snap_sel;
  logic [P_WEIGHT_WIDTH-1:0] w_sel;
  logic [PROD_W-1:0]         prod;
  logic                      fire;

  // Weights are read live each ACCUM cycle; only the traces are frozen.
  assign snap_sel = snap_q[idx_q*P_INPUT_WIDTH +: P_INPUT_WIDTH];
  assign w_sel    = i_weights[idx_q*P_WEIGHT_WIDTH +: P_WEIGHT_WIDTH];
  assign prod     = PROD_W'(snap_sel) * PROD_W'(w_sel);
  assign fire     = (acc_q > i_threshold);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    snap_d  = snap_q;
    valid_d = 1'b0;
    fire_d  = 1'b0;
    lv_d    = lv_q;
    nout_d  = nout_q;
    case (state_q)
      S_IDLE: begin
        if (i_eval) begin
          snap_d  = o_tr;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + P_ACC_W'(prod);
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DONE: begin
        valid_d = 1'b1;
        fire_d  = fire;
        lv_d    = acc_q;
        nout_d  = fire ? acc_q : '0;
        if (fire && (P_REFRACT > 0)) begin
          cnt_d   = REFRACT_LOAD;
          state_d = S_REFRACT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REFRACT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      fire_q  <= 1'b0;
      lv_q    <= '0;
      nout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      fire_q  <= fire_d;
      lv_q    <= lv_d;
      nout_q  <= nout_d;
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_valid      = valid_q;
  assign o_fire       = fire_q;
  assign o_lv         = lv_q;
  assign o_neuron_out = nout_q;

endmodule

// File: doc/neuron_nin.md
Name: neuron_nin

Overview:
- Parametrised successor to the 8-input leaky-trace neuron: N synapse channels, each with a decaying time-surface trace, each trace weighted and summed.
- Summation is time-multiplexed through one multiply-accumulate unit, one channel per cycle, instead of an N-input adder tree.
- Adds an evaluate handshake, a strict-threshold fire decision, a registered last-value, and a refractory window.
- Sits in the ODESA layer between event routing and the winner-take-all and weight-update logic.

Parameters:
- P_N_INPUTS, 8, number of synapse channels (>=2).
- P_INPUT_WIDTH, 9, trace width; trace maximum is 2^P_INPUT_WIDTH-1.
- P_WEIGHT_WIDTH, 9, unsigned weight width.
- P_DECAY, 1, amount subtracted from each trace per clock.
- P_REFRACT, 16, refractory cycles after a fire (0 disables the window).
- Derived, P_ACC_W = P_INPUT_WIDTH+P_WEIGHT_WIDTH+clog2(P_N_INPUTS), accumulator, threshold and output width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_event  in  P_N_INPUTS  per-channel input spike, one cycle each.
- i_weights  in  P_N_INPUTS*P_WEIGHT_WIDTH  flattened weights; channel k occupies slice k.
- i_threshold  in  P_ACC_W  fire threshold.
- i_eval  in  1  evaluation request.
- o_busy  out  1  high whenever i_eval would not be accepted.
- o_tr  out  P_N_INPUTS*P_INPUT_WIDTH  live traces, flattened.
- o_valid  out  1  one-cycle pulse when a result is ready.
- o_fire  out  1  qualified by o_valid; high when the sum exceeds the threshold.
- o_lv  out  P_ACC_W  last accumulated sum, held.
- o_neuron_out  out  P_ACC_W  sum if fired, else 0; held.

Behaviour:
- Reset (asynchronous): all traces, o_lv, o_neuron_out and the accumulator go to 0; o_valid, o_fire and o_busy go to 0; FSM goes to IDLE.
- Trace update, per channel, each edge:
  - if i_event[k] is high, trace becomes max; the reload wins over decay in the same cycle;
  - otherwise trace becomes trace-P_DECAY, saturating at 0.
- FSM states: IDLE, ACCUM, DONE, REFRACT.
- IDLE:
  - i_eval accepted when high: snapshot all traces into a capture array, clear the accumulator, index=0, go to ACCUM;
  - o_busy is 0 only in IDLE.
- ACCUM:
  - each cycle, acc += snap[index]*w[index], where w is sampled live that cycle;
  - index increments; after index P_N_INPUTS-1, go to DONE;
  - takes exactly P_N_INPUTS cycles.
- DONE (one cycle):
  - o_valid=1;
  - o_fire=(acc > i_threshold), strict comparison;
  - o_lv=acc;
  - o_neuron_out=acc if fired, else 0;
  - next state is REFRACT if fired and P_REFRACT>0, else IDLE.
- Latency: i_eval sampled at edge T gives o_valid high in the cycle after edge T+P_N_INPUTS+1.
- REFRACT:
  - down-counter loaded with P_REFRACT; returns to IDLE when it reaches 0;
  - o_busy stays high throughout.
- i_eval while o_busy is high is dropped, not queued.
- Traces keep updating in every state; events arriving during ACCUM do not affect the in-flight sum because of the snapshot.
- Width rules:
  - the product is P_INPUT_WIDTH+P_WEIGHT_WIDTH bits, zero-extended;
  - the accumulator cannot overflow by construction;
  - all arithmetic is unsigned.
- o_lv and o_neuron_out hold their value until the next DONE.
- Reset mid-ACCUM or mid-REFRACT aborts immediately; no o_valid is produced.

Decomposition:
- Package neuron_pkg holds:
  - the FSM state enum;
  - a clog2 constant function;
  - the P_ACC_W derivation helper.
- Sub-module neuron_trace: one saturating decaying trace; ports i_clk, i_rst, i_event, o_tr; parameters width and decay. Instantiated P_N_INPUTS times via generate.
- MAC, FSM and refractory counter stay in the top level.

Test Plan:
All scenarios use defaults unless stated (trace maximum 511).
- Reset: assert i_rst mid-ACCUM -> all outputs 0 within the same cycle, no o_valid, o_busy=0 after release.
- Decay and saturation: event on channel 0, no eval -> o_tr[0] reads 511, then 510, and so on down to 0 after 511 cycles, then stays 0; an event on the same cycle as decay reloads to 511.
- Fire: event on channel 0, weight0=2, other weights 0, i_eval 10 cycles later -> snapshot 501, o_valid at the computed latency, sum 1002.
  - threshold=1000: o_fire=1, o_neuron_out=1002, o_lv=1002.
  - threshold=1002: o_fire=0, o_neuron_out=0, o_lv=1002.
- Snapshot isolation: events on all channels during ACCUM -> result equals the pre-eval snapshot sum.
- Refractory: after a fire with P_REFRACT=16 -> o_busy high for 16 cycles after DONE; i_eval during that window produces no o_valid; i_eval after it is accepted.
- Channel scaling: P_N_INPUTS=16, all weights 511, all traces 511 -> sum 16*511*511=4177936, no overflow at P_ACC_W=22, latency 18 cycles.
